// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin arbiter in front of a 32x64 regfile with zero-init sweep and XZR handling.
// Optional RF_BYPASS_EN: a read of the register written by the same transaction returns the new data.
module regfile_arbiter #(
  parameter int NREQ = 2,
  parameter int DW = 64,
  parameter int AW = 5,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_waddr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ*AW-1:0] req_raddr1,
  input  logic [NREQ*AW-1:0] req_raddr2,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [DW-1:0]     rsp_rdata1,
  output logic [DW-1:0]     rsp_rdata2,
  output logic              init_done,
  output logic              rf_RegWrite,
  output logic [AW-1:0]     rf_WriteRegister,
  output logic [DW-1:0]     rf_WriteData,
  output logic [AW-1:0]     rf_ReadRegister1,
  output logic [AW-1:0]     rf_ReadRegister2,
  input  logic [DW-1:0]     rf_ReadData1,
  input  logic [DW-1:0]     rf_ReadData2
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [AW-1:0] XZR = '1;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic init_done_q, init_done_d;
  logic [IW-1:0] last_q, last_d, gnt, cand;
  logic found, accept, wr_ok, byp1, byp2;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] wd;
  logic rsp_valid_q, rsp_valid_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;
  logic [DW-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    cand = '0;
    for (int j = 1; j <= NREQ; j++) begin
      cand = IW'((int'(last_q) + j) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt = cand;
      end
    end
    accept = (state_q == RUN) && found;
    req_ready = '0;
    if (accept) req_ready[gnt] = 1'b1;
  end
  assign ra1 = accept ? req_raddr1[gnt*AW +: AW] : '0;
  assign ra2 = accept ? req_raddr2[gnt*AW +: AW] : '0;
  assign wa = accept ? req_waddr[gnt*AW +: AW] : '0;
  assign wd = accept ? req_wdata[gnt*DW +: DW] : '0;
  assign wr_ok = accept && req_we[gnt] && (wa != XZR);
`ifdef RF_BYPASS_EN
  assign byp1 = wr_ok && (ra1 == wa);
  assign byp2 = wr_ok && (ra2 == wa);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  // The sweep write enable is gated by rst_n so every output reads 0 while reset is held.
  assign rf_RegWrite = (state_q == INIT) ? rst_n : wr_ok;
  assign rf_WriteRegister = (state_q == INIT) ? cnt_q : wa;
  assign rf_WriteData = (state_q == INIT) ? '0 : wd;
  assign rf_ReadRegister1 = ra1;
  assign rf_ReadRegister2 = ra2;
  always_comb begin
    state_d = (state_q == INIT && cnt_q == XZR) ? RUN : state_q;
    cnt_d = (state_q == INIT) ? cnt_q + 1'b1 : cnt_q;
    init_done_d = init_done_q | (state_q == INIT && cnt_q == XZR);
    last_d = accept ? gnt : last_q;
    rsp_valid_d = accept;
    rsp_id_d = accept ? gnt : rsp_id_q;
    rdata1_d = !accept ? rdata1_q : (ra1 == XZR) ? '0 : byp1 ? wd : rf_ReadData1;
    rdata2_d = !accept ? rdata2_q : (ra2 == XZR) ? '0 : byp2 ? wd : rf_ReadData2;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q <= '0;
      init_done_q <= 1'b0;
      last_q <= IW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      init_done_q <= init_done_d;
      last_q <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_rdata1 = rdata1_q;
  assign rsp_rdata2 = rdata2_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: randomized bench for regfile_arbiter against an array-based reference model.
module tb_regfile_arbiter;
  localparam int NREQ = 2, DW = 64, AW = 5, IW = 1;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst_n;
  logic [NREQ-1:0] req_valid, req_ready, req_we;
  logic [NREQ*AW-1:0] req_waddr, req_raddr1, req_raddr2;
  logic [NREQ*DW-1:0] req_wdata;
  logic rsp_valid, init_done, rf_RegWrite;
  logic [IW-1:0] rsp_id;
  logic [DW-1:0] rsp_rdata1, rsp_rdata2, rf_WriteData, rf_ReadData1, rf_ReadData2;
  logic [AW-1:0] rf_WriteRegister, rf_ReadRegister1, rf_ReadRegister2;
  logic [NREQ-1:0] v, we;
  logic [AW-1:0] wa [NREQ], r1 [NREQ], r2 [NREQ];
  logic [DW-1:0] wd [NREQ];
  logic [DW-1:0] env_mem [32];
  logic [DW-1:0] ref_mem [32];
  int last, errors = 0, checks = 0;
  always #5 clk = ~clk;
  regfile_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_raddr1(req_raddr1), .req_raddr2(req_raddr2),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2),
    .init_done(init_done), .rf_RegWrite(rf_RegWrite), .rf_WriteRegister(rf_WriteRegister),
    .rf_WriteData(rf_WriteData), .rf_ReadRegister1(rf_ReadRegister1), .rf_ReadRegister2(rf_ReadRegister2),
    .rf_ReadData1(rf_ReadData1), .rf_ReadData2(rf_ReadData2));
  always_comb begin
    req_valid = v;
    req_we = we;
    req_waddr = '0;
    req_wdata = '0;
    req_raddr1 = '0;
    req_raddr2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_waddr[i*AW +: AW] = wa[i];
      req_wdata[i*DW +: DW] = wd[i];
      req_raddr1[i*AW +: AW] = r1[i];
      req_raddr2[i*AW +: AW] = r2[i];
    end
  end
  // Register file stand-in: garbage while in reset so the sweep has something to clear.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= {$urandom, $urandom};
    end else if (rf_RegWrite) env_mem[rf_WriteRegister] <= rf_WriteData;
  end
  assign rf_ReadData1 = env_mem[rf_ReadRegister1];
  assign rf_ReadData2 = env_mem[rf_ReadRegister2];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_req(input int i, input bit vv, input bit w, input int a, input logic [63:0] d,
                         input int a1, input int a2);
    v[i] = vv;
    we[i] = w;
    wa[i] = AW'(a);
    wd[i] = d;
    r1[i] = AW'(a1);
    r2[i] = AW'(a2);
  endtask
  task automatic idle();
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0, 0, 0);
  endtask
  function automatic logic [63:0] exp_rd(input int ra, input int g);
    if (ra == 31) return 64'd0;
    if (BYP && we[g] && wa[g] != 31 && ra == int'(wa[g])) return wd[g];
    return ref_mem[ra];
  endfunction
  task automatic step();
    int g;
    logic [63:0] e1, e2;
    logic [NREQ-1:0] er;
    @(negedge clk);
    g = -1;
    for (int j = 1; j <= NREQ; j++) begin
      int c;
      c = (last + j) % NREQ;
      if (g < 0 && v[c]) g = c;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    e1 = 0;
    e2 = 0;
    if (g >= 0) begin
      check("rf_RegWrite", 64'(rf_RegWrite), 64'(we[g] && wa[g] != 31));
      check("rf_ReadRegister1", 64'(rf_ReadRegister1), 64'(r1[g]));
      e1 = exp_rd(int'(r1[g]), g);
      e2 = exp_rd(int'(r2[g]), g);
    end else begin
      check("rf_RegWrite_idle", 64'(rf_RegWrite), 64'd0);
    end
    @(posedge clk);
    if (g >= 0) begin
      if (we[g] && wa[g] != 31) ref_mem[wa[g]] = wd[g];
      last = g;
    end
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(g >= 0));
    if (g >= 0) begin
      check("rsp_id", 64'(rsp_id), 64'(g));
      check("rsp_rdata1", rsp_rdata1, e1);
      check("rsp_rdata2", rsp_rdata2, e2);
    end
  endtask
  task automatic init_sweep();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 3, 64'hAA, 1, 2);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      check("init_we", 64'(rf_RegWrite), 64'd1);
      check("init_addr", 64'(rf_WriteRegister), 64'(k));
      check("init_data", rf_WriteData, 64'd0);
      check("init_ready", 64'(req_ready), 64'd0);
      check("init_done_low", 64'(init_done), 64'd0);
    end
    idle();
    @(negedge clk);
    check("init_done_high", 64'(init_done), 64'd1);
    check("post_init_we", 64'(rf_RegWrite), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
    last = NREQ - 1;
  endtask
  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 64'(rf_RegWrite), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_waddr", 64'(rf_WriteRegister), 64'd0);
    init_sweep();
    set_req(0, 1, 0, 0, 0, 7, 7);
    step();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, 0, i + 1, 0);
    repeat (4) step();
    idle();
    set_req(1, 1, 1, 5, 64'hDEAD_BEEF, 0, 0);
    step();
    idle();
    set_req(0, 1, 0, 0, 0, 5, 0);
    step();
    idle();
    set_req(0, 1, 1, 9, 64'h1234, 9, 0);
    step();
    set_req(0, 1, 0, 0, 0, 9, 9);
    step();
    idle();
    set_req(1, 1, 1, 31, 64'hFFFF, 31, 31);
    step();
    set_req(1, 1, 0, 0, 0, 31, 5);
    step();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, bit'($urandom % 2), bit'($urandom % 2),
                ($urandom % 4 == 0) ? 31 : int'($urandom % 8), {$urandom, $urandom},
                ($urandom % 4 == 0) ? 31 : int'($urandom % 8), int'($urandom % 8));
      step();
    end
    idle();
    set_req(0, 1, 1, 5, 64'h55, 5, 5);
    @(negedge clk);
    check("pre_rst_ready", 64'(req_ready), 64'(1) << ((last + 1) % NREQ == 0 ? 0 : 0));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_init_done", 64'(init_done), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    check("midrst_we", 64'(rf_RegWrite), 64'd0);
    @(posedge clk);
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    init_sweep();
    set_req(0, 1, 0, 0, 0, 5, 0);
    step();
    check("x5_after_reset", rsp_rdata1, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
Controller in front of the 32x64 register file (regfile). It shares the register file's single write port and two read ports between NREQ requesters, for example the pipeline and the debug/loader, using a round-robin, one-transaction-per-cycle valid/ready handshake. The register file has no functional reset, so after every reset this block runs a zero-initialisation sweep of all 32 registers. It also enforces LEGv8 XZR semantics: X31 reads as zero and writes to it are discarded.

Parameters:
NREQ, 2, number of requesters (2..4)
DW, 64, data width
AW, 5, register address width (32 registers)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester transaction valid
req_ready  out  NREQ  per-requester grant; one-hot or zero
req_we  in  NREQ  transaction includes a write
req_waddr  in  NREQ*AW  write address; requester i in slice i
req_wdata  in  NREQ*DW  write data
req_raddr1  in  NREQ*AW  read address 1
req_raddr2  in  NREQ*AW  read address 2
rsp_valid  out  1  response strobe, one cycle per accepted transaction
rsp_id  out  clog2(NREQ)  index of the requester being answered
rsp_rdata1  out  DW  read data 1
rsp_rdata2  out  DW  read data 2
init_done  out  1  high once the zero sweep has finished
rf_RegWrite  out  1  register file write enable
rf_WriteRegister  out  AW  register file write address
rf_WriteData  out  DW  register file write data
rf_ReadRegister1  out  AW  register file read address 1
rf_ReadRegister2  out  AW  register file read address 2
rf_ReadData1  in  DW  register file read data 1 (combinational read)
rf_ReadData2  in  DW  register file read data 2 (combinational read)

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0. State=INIT, sweep counter=0, round-robin pointer set so requester 0 has highest priority.
- INIT:
  - Cycle k (k=0..31) drives rf_RegWrite=1, rf_WriteRegister=k, rf_WriteData=0.
  - req_ready=0 throughout.
  - After the posedge that writes register 31: state=RUN, init_done=1 (registered). init_done stays 1 until the next reset.
  - Accepting the first transaction is therefore possible no earlier than the 33rd cycle after reset release.
- RUN, arbitration:
  - req_ready is combinational from req_valid and the pointer; at most one bit is set.
  - Search order starts at last_granted+1 and wraps modulo NREQ.
  - A transaction is accepted when req_valid[i]&req_ready[i]. The pointer updates to i on acceptance only.
  - Requesters must not derive req_valid from req_ready.
- RUN, datapath on acceptance (same cycle):
  - rf_ReadRegister1/2 = granted raddr1/2.
  - rf_RegWrite = req_we & (waddr != 31).
  - rf_WriteRegister / rf_WriteData = granted waddr / wdata.
  - With no grant: rf_RegWrite=0 and rf_* addresses hold 0.
- Response:
  - Registered; latency 1. The cycle after acceptance: rsp_valid=1, rsp_id=i.
  - rsp_rdata1/2 = rf_ReadData1/2 sampled at acceptance, forced to 0 when the corresponding address is 31.
  - No response backpressure; rsp_valid=0 in all other cycles. Data outputs hold their last value.
- Same-transaction read of the register being written: without the optional feature, returns the old value (the write lands at the posedge).
- Back-to-back: a write accepted in cycle n is visible to any read accepted in cycle n+1 or later.
- Reset mid-sweep or mid-transaction: the in-flight response is dropped (rsp_valid=0), the sweep restarts at register 0, and init_done falls immediately.

Optional Feature:
RF_BYPASS_EN
- Defined: when the accepted transaction has req_we=1, waddr!=31 and raddrN==waddr, rsp_rdataN returns that transaction's wdata instead of the old register value.
- Undefined: the old register value is returned, as stated above. No other behaviour changes.

Test Plan:
- Reset release -> rf_RegWrite=1 for exactly 32 cycles with addresses 0..31 and data 0, req_ready=0 throughout, init_done=1 in cycle 32. A read of X7 then returns 0.
- Both requesters hold valid continuously (NREQ=2) -> grants alternate 0,1,0,1; each rsp_id matches its grant one cycle later; zero idle cycles.
- Requester 1 writes X5=0xDEAD_BEEF; the next cycle requester 0 reads raddr1=5, raddr2=0 -> rsp_rdata1=0xDEAD_BEEF, rsp_rdata2=0.
- Single transaction writes X9=0x1234 and reads raddr1=9 -> rsp_rdata1=0 without RF_BYPASS_EN, 0x1234 with it. A later read of X9 returns 0x1234 in both builds.
- Write X31=0xFFFF then read X31 -> rf_RegWrite=0 during the write, rsp_rdata1=0.
- rst_n pulsed low during a RUN grant -> rsp_valid=0 the next cycle, init_done=0, sweep restarts at register 0, and X5 reads 0 after init_done.
